muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
- Iterative, multi-cycle multiply/divide unit that replaces the single-cycle combinational mult/div path in the execute stage.
- Feeds the hi/lo register unit directly: its hi/lo outputs drive that unit's write-data inputs, and its hilo_we output drives that unit's write enable.
- Uses a start/busy/done handshake so the pipeline controller can stall while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits.
- CNTW, 6, iteration counter width; must satisfy 2^CNTW > WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset: reset=0 clears the block immediately, regardless of clk.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  operation: 00 multu, 01 mult (signed), 10 divu, 11 div (signed).
- a  input  WIDTH  multiplicand or dividend.
- b  input  WIDTH  multiplier or divisor.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; hi and lo are valid while it is high.
- hilo_we  output  1  equal to done; write enable for the hi/lo registers.
- hi  output  WIDTH  multiply: upper product half; divide: remainder.
- lo  output  WIDTH  multiply: lower product half; divide: quotient.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; busy=0, done=0, hilo_we=0, hi=0, lo=0.
  - Counter and working registers are cleared.
  - Any operation in progress is abandoned and produces no done pulse.
- States: IDLE, RUN, FIX, DONE.
- IDLE, start=1 at edge E0:
  - Latch op, a, and the sign flags sa=a[WIDTH-1], sb=b[WIDTH-1]. Sign flags are used only for signed ops.
  - Latch |a| and |b| for signed ops; latch the raw operands for unsigned ops.
  - Load counter=WIDTH and go to RUN.
- Divide by zero: if op[1]=1 and b=0 at E0, go to FIX directly and skip RUN.
- start=0 in IDLE: remain in IDLE; hi/lo hold their previous values.
- RUN: one iteration per cycle; counter decrements each iteration.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; each iteration yields one quotient bit.
  - At the edge where counter reaches 0, go to FIX. This gives WIDTH RUN edges (E1..E32 at default).
- FIX, at E33 (or E1 for divide by zero):
  - Signed multiply: negate the 2*WIDTH product if sa^sb.
  - Signed divide: negate the quotient if sa^sb; negate the remainder if sa.
  - Divide by zero: lo=all ones, hi=a as latched, for both signed and unsigned divide.
  - Register hi/lo and go to DONE.
- DONE: done=1 and hilo_we=1 for exactly one cycle, then go to IDLE on the next edge.
- Latency: done is high in the 34th cycle after the start-sampling edge (WIDTH+2), or the 2nd cycle for divide by zero. A new start is accepted no earlier than the cycle after DONE.
- start while busy=1, including in DONE: ignored. The running operation is unaffected.
- Operand changes on a, b or op after E0 have no effect.
- hi/lo change only at the FIX edge and at reset; they hold between operations.
- Overflow, div -2^31 / -1: lo=0x80000000, hi=0. No exception is raised.
- All arithmetic is modulo 2^WIDTH per half; there are no X or undefined results.

Test Plan:
- Reset: drive reset=0 mid-RUN (counter about 10) -> busy, done, hi and lo are 0 immediately, before the next clk edge. After reset=1, no done pulse appears, and a fresh start then completes normally.
- multu: a=0xFFFFFFFF, b=2 -> done in cycle 34 with hi=0x00000001, lo=0xFFFFFFFE. hilo_we=done, busy low the following cycle.
- mult signed:
  - a=0xFFFFFFFF, b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0.
- divu and div:
  - divu a=100, b=7 -> lo=14, hi=2.
  - div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - div a=7, b=-2 -> lo=0xFFFFFFFD, hi=1.
  - div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: divu a=0x1234, b=0 -> done in cycle 2 with lo=0xFFFFFFFF, hi=0x1234. Same for div.
- Handshake: pulse start with different operands in cycles 5, 20 and DONE of a running op -> the original result is unchanged and there is exactly one done pulse. A start in the cycle after DONE is accepted. With start=0 for 50 cycles, hi/lo hold and done never rises.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a start/busy/done handshake feeding the hi/lo registers.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t               state_reg, state_next;
    logic [CNTW-1:0]      cnt_reg, cnt_next;
    logic [1:0]           op_reg, op_next;
    logic                 sa_reg, sa_next;
    logic                 sb_reg, sb_next;
    logic [WIDTH-1:0]     a_raw_reg, a_raw_next;
    logic [WIDTH-1:0]     ub_reg, ub_next;
    logic [2*WIDTH-1:0]   acc_reg, acc_next;
    logic [WIDTH-1:0]     hi_reg, hi_next;
    logic [WIDTH-1:0]     lo_reg, lo_next;

    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step;
    logic [WIDTH:0]       div_trial, div_diff;
    logic [2*WIDTH-1:0]   div_step;
    logic [2*WIDTH-1:0]   prod_neg;
    logic [WIDTH-1:0]     quo_neg, rem_neg;

    // Magnitudes only for signed ops; unsigned ops keep the raw operands.
    assign abs_a = (op[0] && a[WIDTH-1]) ? -a : a;
    assign abs_b = (op[0] && b[WIDTH-1]) ? -b : b;

    // acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, ub_reg} : '0);
    assign mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

    // acc = {partial remainder, dividend/quotient}, shifted left each step.
    assign div_trial = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_diff  = div_trial - {1'b0, ub_reg};
    assign div_step  = (div_trial >= {1'b0, ub_reg})
                     ? {div_diff[WIDTH-1:0],  acc_reg[WIDTH-2:0], 1'b1}
                     : {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};

    assign prod_neg = -acc_reg;
    assign quo_neg  = -acc_reg[WIDTH-1:0];
    assign rem_neg  = -acc_reg[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            op_reg    <= '0;
            sa_reg    <= 1'b0;
            sb_reg    <= 1'b0;
            a_raw_reg <= '0;
            ub_reg    <= '0;
            acc_reg   <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            sa_reg    <= sa_next;
            sb_reg    <= sb_next;
            a_raw_reg <= a_raw_next;
            ub_reg    <= ub_next;
            acc_reg   <= acc_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        sa_next    = sa_reg;
        sb_next    = sb_reg;
        a_raw_next = a_raw_reg;
        ub_next    = ub_reg;
        acc_next   = acc_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    op_next    = op;
                    sa_next    = a[WIDTH-1];
                    sb_next    = b[WIDTH-1];
                    a_raw_next = a;
                    ub_next    = abs_b;
                    acc_next   = {{WIDTH{1'b0}}, abs_a};
                    cnt_next   = CNTW'(WIDTH);
                    state_next = (op[1] && (b == '0)) ? FIX : RUN;
                end
            end
            RUN: begin
                acc_next = op_reg[1] ? div_step : mul_step;
                cnt_next = cnt_reg - CNTW'(1);
                if (cnt_reg == CNTW'(1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                if (!op_reg[1]) begin
                    {hi_next, lo_next} = (op_reg[0] && (sa_reg ^ sb_reg)) ? prod_neg : acc_reg;
                end else if (ub_reg == '0) begin
                    // A zero divisor magnitude can only come from b == 0.
                    hi_next = a_raw_reg;
                    lo_next = '1;
                end else begin
                    lo_next = (op_reg[0] && (sa_reg ^ sb_reg)) ? quo_neg : acc_reg[WIDTH-1:0];
                    hi_next = (op_reg[0] && sa_reg) ? rem_neg : acc_reg[2*WIDTH-1:WIDTH];
                end
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == DONE);
    assign hilo_we = done;
    assign hi      = hi_reg;
    assign lo      = lo_reg;

endmodule
